// File: rtl/pong_pkg.sv
// Shared encodings for the pong ball controller.
// Holds the per-axis step codes, the FSM state enum and small helpers.
package pong_pkg;

  localparam logic [1:0] STEP_ZERO = 2'b00;
  localparam logic [1:0] STEP_POS  = 2'b01;
  localparam logic [1:0] STEP_NEG  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_DONE
  } ball_state_e;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } vec_t;

  localparam vec_t VEC_ZERO = '{x: STEP_ZERO, y: STEP_ZERO};

  // Score counter that parks at the limit instead of wrapping.
  function automatic logic [3:0] sat_inc(
    input logic [3:0] v,
    input logic [3:0] lim
  );
    return (v < lim) ? v + 4'd1 : v;
  endfunction

endpackage

// File: rtl/ball_ctrl_hit.sv
// Paddle span compare: is the ball row inside [pad, pad+PAD_LEN-1]?
// Ports: pad_i top row of paddle, y_i ball row, hit_o row is covered.
module ball_ctrl_hit #(
  parameter int BIT_OF_WIDTH = 3,
  parameter int PAD_LEN      = 3
) (
  input  logic [BIT_OF_WIDTH-1:0] pad_i,
  input  logic [BIT_OF_WIDTH-1:0] y_i,
  output logic                    hit_o
);

  // One extra bit so a paddle hanging off the bottom edge
  // does not wrap around to the top rows.
  localparam int EW = BIT_OF_WIDTH + 1;
  localparam logic [EW-1:0] SPAN = EW'(PAD_LEN - 1);

  logic [EW-1:0] lo;
  logic [EW-1:0] hi;
  logic [EW-1:0] yy;

  assign lo = {1'b0, pad_i};
  assign hi = lo + SPAN;
  assign yy = {1'b0, y_i};

  assign hit_o = (yy >= lo) && (yy <= hi);

endmodule

// File: rtl/ball_ctrl.sv
// Pong rally/score FSM: steers the ball step vector and keeps score.
// Ports: clk, rst (sync high), start, serve_dir, pad_l, pad_r, pos
//   in; en, vector, score_l, score_r, point_l, point_r, game_over out.
// Option: BALL_CTRL_AUTO_SERVE_EN re-serves after a point without
//   start, toward the side that conceded.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PAD_LEN      = 3,
  parameter int MAX_SCORE    = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      serve_dir,
  input  logic [BIT_OF_WIDTH-1:0]   pad_l,
  input  logic [BIT_OF_WIDTH-1:0]   pad_r,
  input  logic [2*BIT_OF_WIDTH-1:0] pos,
  output logic                      en,
  output logic [3:0]                vector,
  output logic [3:0]                score_l,
  output logic [3:0]                score_r,
  output logic                      point_l,
  output logic                      point_r,
  output logic                      game_over
);

  localparam int BW = BIT_OF_WIDTH;

  localparam logic [BW-1:0] C_ZERO = '0;
  localparam logic [BW-1:0] C_MAX  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] C_LPAD = BW'(1);
  localparam logic [BW-1:0] C_RPAD = BW'(WIDTH - 2);
  localparam logic [3:0]    SC_MAX = 4'(MAX_SCORE);

  ball_state_e state_q, state_d;
  vec_t        vec_q, vec_d;
  logic [3:0]  sl_q, sl_d;
  logic [3:0]  sr_q, sr_d;
  logic        pl_q, pl_d;
  logic        pr_q, pr_d;
  logic        en_q, en_d;
  logic        go_q, go_d;

  logic [BW-1:0] x;
  logic [BW-1:0] y;
  logic          hit_l;
  logic          hit_r;
  logic [1:0]    x_nx;
  logic [1:0]    y_nx;
  logic          sdir;
  logic          won;

  assign x = pos[2*BW-1:BW];
  assign y = pos[BW-1:0];

  ball_ctrl_hit #(
    .BIT_OF_WIDTH (BW),
    .PAD_LEN      (PAD_LEN)
  ) u_hit_l (
    .pad_i (pad_l),
    .y_i   (y),
    .hit_o (hit_l)
  );

  ball_ctrl_hit #(
    .BIT_OF_WIDTH (BW),
    .PAD_LEN      (PAD_LEN)
  ) u_hit_r (
    .pad_i (pad_r),
    .y_i   (y),
    .hit_o (hit_r)
  );

`ifdef BALL_CTRL_AUTO_SERVE_EN
  // adir_q: direction toward the side that last conceded.
  // auto_q: the pending serve came from a point, not from start.
  logic adir_q, adir_d;
  logic auto_q, auto_d;

  assign sdir = auto_q ? adir_q : serve_dir;
`else
  assign sdir = serve_dir;
`endif

  // Wall and paddle bounces are independent per axis, so a
  // corner hit naturally flips both steps.
  always_comb begin
    y_nx = vec_q.y;
    if (y == C_ZERO && vec_q.y == STEP_NEG) begin
      y_nx = STEP_POS;
    end else if (y == C_MAX && vec_q.y == STEP_POS) begin
      y_nx = STEP_NEG;
    end

    x_nx = vec_q.x;
    if (x == C_LPAD && vec_q.x == STEP_NEG && hit_l) begin
      x_nx = STEP_POS;
    end else if (x == C_RPAD && vec_q.x == STEP_POS && hit_r) begin
      x_nx = STEP_NEG;
    end
  end

  assign won = (sl_q == SC_MAX) || (sr_q == SC_MAX);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    pl_d    = 1'b0;
    pr_d    = 1'b0;
`ifdef BALL_CTRL_AUTO_SERVE_EN
    adir_d  = adir_q;
    auto_d  = auto_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        vec_d = VEC_ZERO;
        if (start) begin
          state_d = ST_SERVE;
`ifdef BALL_CTRL_AUTO_SERVE_EN
          auto_d  = 1'b0;
`endif
        end
      end

      ST_SERVE: begin
        vec_d.x = sdir ? STEP_POS : STEP_NEG;
        vec_d.y = STEP_POS;
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (x == C_ZERO) begin
          sr_d    = sat_inc(sr_q, SC_MAX);
          pr_d    = 1'b1;
          vec_d   = VEC_ZERO;
          state_d = ST_POINT;
`ifdef BALL_CTRL_AUTO_SERVE_EN
          adir_d  = 1'b0;
`endif
        end else if (x == C_MAX) begin
          sl_d    = sat_inc(sl_q, SC_MAX);
          pl_d    = 1'b1;
          vec_d   = VEC_ZERO;
          state_d = ST_POINT;
`ifdef BALL_CTRL_AUTO_SERVE_EN
          adir_d  = 1'b1;
`endif
        end else begin
          vec_d.x = x_nx;
          vec_d.y = y_nx;
        end
      end

      ST_POINT: begin
        vec_d = VEC_ZERO;
        if (won) begin
          state_d = ST_DONE;
        end else begin
`ifdef BALL_CTRL_AUTO_SERVE_EN
          state_d = ST_SERVE;
          auto_d  = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end

      ST_DONE: begin
        vec_d = VEC_ZERO;
      end

      default: begin
        state_d = ST_IDLE;
        vec_d   = VEC_ZERO;
      end
    endcase

    en_d = (state_d == ST_PLAY);
    go_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= VEC_ZERO;
      sl_q    <= '0;
      sr_q    <= '0;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
      en_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      en_q    <= en_d;
      go_q    <= go_d;
    end
  end

`ifdef BALL_CTRL_AUTO_SERVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      adir_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      adir_q <= adir_d;
      auto_q <= auto_d;
    end
  end
`endif

  assign en        = en_q;
  assign vector    = vec_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign point_l   = pl_q;
  assign point_r   = pr_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Scoreboard bench for ball_ctrl: directed rally scenarios, then
// random traffic against a game-level model of the rules.
module tb_ball_ctrl;

  localparam int W  = 8;
  localparam int BW = 3;
  localparam int PL = 3;
  localparam int MX = 9;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_DONE  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            serve_dir;
  logic [BW-1:0]   pad_l;
  logic [BW-1:0]   pad_r;
  logic [2*BW-1:0] pos;
  logic            en;
  logic [3:0]      vector;
  logic [3:0]      score_l;
  logic [3:0]      score_r;
  logic            point_l;
  logic            point_r;
  logic            game_over;

  ball_ctrl #(
    .WIDTH        (W),
    .BIT_OF_WIDTH (BW),
    .PAD_LEN      (PL),
    .MAX_SCORE    (MX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .serve_dir (serve_dir),
    .pad_l     (pad_l),
    .pad_r     (pad_r),
    .pos       (pos),
    .en        (en),
    .vector    (vector),
    .score_l   (score_l),
    .score_r   (score_r),
    .point_l   (point_l),
    .point_r   (point_r),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [3:0] vec;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       pl;
    logic       pr;
    logic       go;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Game-level model: phase, signed steps, integer scores.
  int m_ph  = P_IDLE;
  int m_dx  = 0;
  int m_dy  = 0;
  int m_sl  = 0;
  int m_sr  = 0;
  int m_who = 0;
  bit m_auto = 1'b0;
  int m_adir = 1;

  function automatic logic [1:0] enc(input int d);
    if (d > 0) return 2'b01;
    if (d < 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit on_pad(input int top, input int yy);
    return (yy >= top) && (yy <= top + PL - 1);
  endfunction

  task automatic model_step();
    int x;
    int y;
    obs_t e;
    x = int'(pos[2*BW-1:BW]);
    y = int'(pos[BW-1:0]);
    if (rst) begin
      m_ph = P_IDLE; m_dx = 0; m_dy = 0;
      m_sl = 0; m_sr = 0; m_who = 0; m_auto = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_who = 0;
          if (start) begin
            m_ph = P_SERVE;
            m_auto = 1'b0;
          end
        end
        P_SERVE: begin
          if (m_auto) m_dx = m_adir;
          else m_dx = serve_dir ? 1 : -1;
          m_dy = 1;
          m_ph = P_PLAY;
        end
        P_PLAY: begin
          if (x == 0) begin
            if (m_sr < MX) m_sr++;
            m_who = 2; m_adir = -1;
            m_dx = 0; m_dy = 0; m_ph = P_POINT;
          end else if (x == W - 1) begin
            if (m_sl < MX) m_sl++;
            m_who = 1; m_adir = 1;
            m_dx = 0; m_dy = 0; m_ph = P_POINT;
          end else begin
            int nx;
            int ny;
            nx = m_dx;
            ny = m_dy;
            if (y == 0 && m_dy < 0) ny = 1;
            if (y == W - 1 && m_dy > 0) ny = -1;
            if (x == 1 && m_dx < 0 && on_pad(int'(pad_l), y)) nx = 1;
            if (x == W - 2 && m_dx > 0 && on_pad(int'(pad_r), y)) nx = -1;
            m_dx = nx;
            m_dy = ny;
          end
        end
        P_POINT: begin
          m_who = 0;
          if (m_sl >= MX || m_sr >= MX) begin
            m_ph = P_DONE;
          end else begin
`ifdef BALL_CTRL_AUTO_SERVE_EN
            m_ph = P_SERVE;
            m_auto = 1'b1;
`else
            m_ph = P_IDLE;
`endif
          end
        end
        default: ;
      endcase
    end
    e.en  = (m_ph == P_PLAY);
    e.vec = {enc(m_dx), enc(m_dy)};
    e.sl  = 4'(m_sl);
    e.sr  = 4'(m_sr);
    e.pl  = (m_who == 1);
    e.pr  = (m_who == 2);
    e.go  = (m_ph == P_DONE);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {en, vector, score_l, score_r, point_l, point_r, game_over};
        n_checks++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL sb t=%0t actual en=%b vec=%b sl=%0d sr=%0d pl=%b pr=%b go=%b required en=%b vec=%b sl=%0d sr=%0d pl=%b pr=%b go=%b",
                   $time, a.en, a.vec, a.sl, a.sr, a.pl, a.pr, a.go,
                   e.en, e.vec, e.sl, e.sr, e.pl, e.pr, e.go);
        end
      end
    end
  end

  function automatic void check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2*BW-1:0] xy(input int x, input int y);
    return {BW'(x), BW'(y)};
  endfunction

  task automatic wait_en();
    for (int i = 0; i < 12 && !en; i++) cyc();
    check("wait_en", int'(en), 1);
  endtask

  // Win one point for the given side (1 = left scores).
  task automatic score_side(input bit left);
    start = 1'b1;
    pos = xy(3, 3);
    wait_en();
    pos = left ? xy(7, 2) : xy(0, 2);
    cyc();
    pos = xy(3, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; serve_dir = 1'b0;
    pad_l = '0; pad_r = '0; pos = xy(3, 3);
    cyc();
    cyc();
    check("rst_en", int'(en), 0);
    check("rst_vec", int'(vector), 0);
    check("rst_sl", int'(score_l), 0);
    check("rst_go", int'(game_over), 0);

    rst = 1'b0; start = 1'b1; serve_dir = 1'b1;
    cyc();
    check("serve_en", int'(en), 0);
    check("serve_vec", int'(vector), 0);
    start = 1'b0;
    cyc();
    check("play_en", int'(en), 1);
    check("play_vec", int'(vector), 'b0101);

    pos = xy(6, 4); pad_r = 3;
    cyc();
    check("pad_r_vec", int'(vector), 'b1101);
    pos = xy(3, 7);
    cyc();
    check("ywall_vec", int'(vector), 'b1111);
    pos = xy(1, 3); pad_l = 2;
    cyc();
    check("pad_l_vec", int'(vector), 'b0111);
    pos = xy(6, 0); pad_r = 0;
    cyc();
    check("corner_vec", int'(vector), 'b1101);

    pos = xy(7, 2); pad_r = 5;
    cyc();
    check("pt_pulse", int'(point_l), 1);
    check("pt_sl", int'(score_l), 1);
    check("pt_vec", int'(vector), 0);
    pos = xy(3, 3);
    cyc();
    check("pt_clr", int'(point_l), 0);
    check("post_en", int'(en), 0);
    cyc();
`ifdef BALL_CTRL_AUTO_SERVE_EN
    check("auto_en", int'(en), 1);
    check("auto_vec", int'(vector), 'b0101);
`else
    check("idle_en", int'(en), 0);
    check("idle_vec", int'(vector), 0);
`endif

    for (int k = 1; k < MX; k++) score_side(1'b1);
    cyc();
    check("done_go", int'(game_over), 1);
    check("done_sl", int'(score_l), MX);
    for (int k = 0; k < 3; k++) cyc();
    check("done_hold", int'(game_over), 1);
    check("done_en", int'(en), 0);

    rst = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    check("rst2_go", int'(game_over), 0);
    check("rst2_sl", int'(score_l), 0);

    for (int k = 0; k < 3; k++) score_side(1'b0);
    wait_en();
    check("mid_sr", int'(score_r), 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    check("mid_rst_sr", int'(score_r), 0);
    check("mid_rst_vec", int'(vector), 0);
    check("mid_rst_en", int'(en), 0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(299) == 0);
      start = ($urandom_range(3) == 0);
      serve_dir = 1'($urandom_range(1));
      pad_l = BW'($urandom_range(W - 1));
      pad_r = BW'($urandom_range(W - 1));
      r = int'($urandom_range(15));
      if (r < 14) pos = xy(1 + r % 6, int'($urandom_range(W - 1)));
      else pos = xy((r == 14) ? 0 : W - 1, int'($urandom_range(W - 1)));
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
